// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative shift-add multiply / restoring divide unit owning HI/LO
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_wen,
    input  logic             lo_wen,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    counter;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH:0]   mag_m;   // multiplicand (multiply) or divisor (divide) magnitude
    logic [WIDTH:0]   acc;     // product high half / partial remainder
    logic [WIDTH-1:0] sh;      // multiplier bits / dividend-then-quotient bits

    logic             sgn;
    logic             b_zero;
    logic [WIDTH:0]   abs_a;
    logic [WIDTH:0]   abs_b;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH:0]   nxt_acc;
    logic [WIDTH-1:0] nxt_sh;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign sgn    = ~op[0];
    assign b_zero = (b == '0);
    assign abs_a  = (sgn && a[WIDTH-1]) ? -{a[WIDTH-1], a} : {1'b0, a};
    assign abs_b  = (sgn && b[WIDTH-1]) ? -{b[WIDTH-1], b} : {1'b0, b};

    always_comb begin
        add_sum = acc + (sh[0] ? mag_m : '0);
        shifted = {acc[WIDTH-1:0], sh[WIDTH-1]};
        trial   = shifted - mag_m;
        fits    = (shifted >= mag_m);
        if (is_div) begin
            nxt_acc = fits ? trial : shifted;
            nxt_sh  = {sh[WIDTH-2:0], fits};
        end else begin
            nxt_acc = {1'b0, add_sum[WIDTH:1]};
            nxt_sh  = {add_sum[0], sh[WIDTH-1:1]};
        end
        prod     = {nxt_acc[WIDTH-1:0], nxt_sh};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -nxt_sh : nxt_sh;
        rem_fix  = neg_r ? -nxt_acc[WIDTH-1:0] : nxt_acc[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            counter  <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            mag_m    <= '0;
            acc      <= '0;
            sh       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hi_wen) hi <= wdata;
                    if (lo_wen) lo <= wdata;
                    if (flush) begin
                        div_zero <= 1'b0;
                    end else if (start) begin
                        is_div  <= op[1];
                        neg_q   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r   <= sgn & a[WIDTH-1];
                        counter <= '0;
                        acc     <= '0;
                        mag_m   <= op[1] ? abs_b : abs_a;
                        sh      <= op[1] ? abs_a[WIDTH-1:0] : abs_b[WIDTH-1:0];
                        busy    <= 1'b1;
                        // Divide by zero skips the iterations and leaves HI/LO untouched
                        if (op[1] && b_zero) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            state    <= S_CALC;
                            div_zero <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        div_zero <= 1'b0;
                    end else begin
                        acc     <= nxt_acc;
                        sh      <= nxt_sh;
                        counter <= counter + CW'(1);
                        if (counter == LAST) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            if (is_div) begin
                                lo <= quo_fix;
                                hi <= rem_fix;
                            end else begin
                                lo <= prod_fix[WIDTH-1:0];
                                hi <= prod_fix[2*WIDTH-1:WIDTH];
                            end
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    if (flush) div_zero <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
